// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/flush/halt controller for a single-issue core
//
// Decides how many front-end stages (pc, if_id, id_ex) must hold each cycle,
// forwards execute-stage jumps to the pc register with zero latency, inserts
// FLUSH_CYCLES bubble cycles after every jump and parks the core in a debug
// halt on request.
//
// Parameters:
//   FLUSH_CYCLES  bubble cycles inserted after a jump (0..7, 0 = no flush)
//
// Build option:
//   PIPE_CTRL_PERF_EN  when defined, stall_cnt_o / jump_cnt_o are saturating
//                      32-bit counters; when undefined they are tied to zero
//                      and no counter flops exist.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   jump_flag_i  in   jump request from execute
//   jump_addr_i  in   [31:0] jump target
//   hold_ex_i    in   execute multi-cycle busy
//   hold_bus_i   in   bus grant lost
//   hold_int_i   in   interrupt controller hold
//   halt_req_i   in   debug halt request
//   hold_flag_o  out  [2:0] hold level: 0 none, 1 pc, 2 if, 3 id
//   jump_flag_o  out  jump to pc register
//   jump_addr_o  out  [31:0] jump target to pc register (0 when no jump)
//   halted_o     out  core is in debug halt
//   stall_cnt_o  out  [31:0] cycles with a non-zero hold level
//   jump_cnt_o   out  [31:0] cycles with a jump request

module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    input  logic        hold_int_i,
    input  logic        halt_req_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        halted_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] jump_cnt_o
);

    // Hold levels. Level 2 (hold if_id only) exists in the encoding but no
    // source in this controller requests it.
    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic       FLUSH_EN   = (FLUSH_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] flush_cnt_q;
    logic [2:0] flush_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // A jump always wins: it (re)starts the flush from any state, including
    // HALT and an in-progress FLUSH. With no flush configured a jump simply
    // returns to IDLE, which also keeps it ahead of a pending halt request.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (jump_flag_i && FLUSH_EN) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
        end else if (jump_flag_i) begin
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (halt_req_i) begin
                        state_d = ST_HALT;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q != 3'd0) begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                    // The count covers the current cycle, so a value of 1
                    // means this is the last bubble.
                    if (flush_cnt_q <= 3'd1) begin
                        state_d = halt_req_i ? ST_HALT : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (!halt_req_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    flush_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Hold level is the maximum of all active sources; later assignments
    // only ever raise the level. Reset holds everything.
    always_comb begin
        hold_flag_o = HOLD_NONE;
        if (hold_bus_i || (state_q == ST_HALT)) begin
            hold_flag_o = HOLD_PC;
        end
        if (jump_flag_i || hold_ex_i || hold_int_i || (state_q == ST_FLUSH)) begin
            hold_flag_o = HOLD_ID;
        end
        if (rst) begin
            hold_flag_o = HOLD_ID;
        end
    end

    always_comb begin
        jump_flag_o = jump_flag_i && !rst;
        jump_addr_o = (jump_flag_i && !rst) ? jump_addr_i : 32'd0;
        halted_o    = (state_q == ST_HALT) && !rst;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] jump_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            jump_cnt_q  <= 32'd0;
        end else begin
            if ((hold_flag_o != HOLD_NONE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (jump_flag_i && (jump_cnt_q != 32'hFFFF_FFFF)) begin
                jump_cnt_q <= jump_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign jump_cnt_o  = jump_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign jump_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl

`timescale 1ns/1ps

module tb_pipe_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i;
    logic        hold_bus_i;
    logic        hold_int_i;
    logic        halt_req_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        halted_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] jump_cnt_o;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .hold_ex_i   (hold_ex_i),
        .hold_bus_i  (hold_bus_i),
        .hold_int_i  (hold_int_i),
        .halt_req_i  (halt_req_i),
        .hold_flag_o (hold_flag_o),
        .jump_flag_o (jump_flag_o),
        .jump_addr_o (jump_addr_o),
        .halted_o    (halted_o),
        .stall_cnt_o (stall_cnt_o),
        .jump_cnt_o  (jump_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are then driven and
    // outputs checked a couple of ns later, well away from any edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jump_flag_i = 1'b0;
        jump_addr_i = 32'h0;
        hold_ex_i   = 1'b0;
        hold_bus_i  = 1'b0;
        hold_int_i  = 1'b0;
        halt_req_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0123;
        halt_req_i  = 1'b1;
        #2;
        checks++;
        if (hold_flag_o !== 3'd3) begin errors++; $display("FAIL rst_hold got=%0d exp=3", hold_flag_o); end
        checks++;
        if (jump_flag_o !== 1'b0) begin errors++; $display("FAIL rst_jump_flag got=%0b exp=0", jump_flag_o); end
        checks++;
        if (jump_addr_o !== 32'h0) begin errors++; $display("FAIL rst_jump_addr got=%h exp=0", jump_addr_o); end
        tick();
        checks++;
        if (halted_o !== 1'b0) begin errors++; $display("FAIL rst_halted got=%0b exp=0", halted_o); end
        rst = 1'b0;
        idle_inputs();
        #2;
        checks++;
        if (hold_flag_o !== 3'd0) begin errors++; $display("FAIL post_rst_hold got=%0d exp=0", hold_flag_o); end
        checks++;
        if (stall_cnt_o !== 32'd0 || jump_cnt_o !== 32'd0) begin
            errors++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stall_cnt_o, jump_cnt_o);
        end
    endtask

    task automatic test_jump();
        logic [2:0] exp_hold [4] = '{3'd3, 3'd3, 3'd3, 3'd0};
        do_reset();
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0100;
        #2;
        checks++;
        if (jump_flag_o !== 1'b1 || jump_addr_o !== 32'h100) begin
            errors++; $display("FAIL jump_pass got=%0b/%h exp=1/00000100", jump_flag_o, jump_addr_o);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                jump_flag_i = 1'b0;
                jump_addr_i = 32'hDEAD_BEEF;
                #2;
                checks++;
                if (jump_addr_o !== 32'h0) begin errors++; $display("FAIL jump_addr_zero[%0d] got=%h exp=0", i, jump_addr_o); end
            end
            checks++;
            if (hold_flag_o !== exp_hold[i]) begin
                errors++; $display("FAIL jump_hold[%0d] got=%0d exp=%0d", i, hold_flag_o, exp_hold[i]);
            end
        end
    endtask

    task automatic test_restart();
        logic [2:0] exp_hold [5] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
        do_reset();
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0100;
        tick();
        jump_addr_i = 32'h0000_0200;
        #2;
        checks++;
        if (jump_addr_o !== 32'h200 || jump_flag_o !== 1'b1) begin
            errors++; $display("FAIL restart_pass got=%0b/%h exp=1/00000200", jump_flag_o, jump_addr_o);
        end
        for (int i = 1; i < 5; i++) begin
            if (i > 1) begin
                tick();
                idle_inputs();
                #2;
            end else begin
                #0;
            end
            checks++;
            if (hold_flag_o !== exp_hold[i]) begin
                errors++; $display("FAIL restart_hold[%0d] got=%0d exp=%0d", i, hold_flag_o, exp_hold[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        hold_bus_i = 1'b1;
        hold_ex_i  = 1'b1;
        #2;
        checks++;
        if (hold_flag_o !== 3'd3) begin errors++; $display("FAIL stall_bus_ex got=%0d exp=3", hold_flag_o); end
        tick();
        hold_ex_i = 1'b0;
        #2;
        checks++;
        if (hold_flag_o !== 3'd1) begin errors++; $display("FAIL stall_bus got=%0d exp=1", hold_flag_o); end
        tick();
        hold_bus_i = 1'b0;
        hold_int_i = 1'b1;
        #2;
        checks++;
        if (hold_flag_o !== 3'd3) begin errors++; $display("FAIL stall_int got=%0d exp=3", hold_flag_o); end
        tick();
        hold_int_i = 1'b0;
        #2;
        checks++;
        if (hold_flag_o !== 3'd0 || halted_o !== 1'b0) begin
            errors++; $display("FAIL stall_idle got=%0d/%0b exp=0/0", hold_flag_o, halted_o);
        end
    endtask

    task automatic test_halt();
        logic       exp_halt [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] exp_hold [7] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick();
            halt_req_i = (i < 5);
            #2;
            checks++;
            if (halted_o !== exp_halt[i] || hold_flag_o !== exp_hold[i]) begin
                errors++; $display("FAIL halt_seq[%0d] got=%0b/%0d exp=%0b/%0d",
                                   i + 1, halted_o, hold_flag_o, exp_halt[i], exp_hold[i]);
            end
        end
    endtask

    task automatic test_halt_jump();
        logic       exp_halt [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0] exp_hold [6] = '{3'd1, 3'd3, 3'd3, 3'd3, 3'd1, 3'd0};
        do_reset();
        tick();
        halt_req_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            jump_flag_i = (i == 1);
            jump_addr_i = (i == 1) ? 32'h0000_0400 : 32'h0;
            halt_req_i  = (i < 4);
            #2;
            checks++;
            if (halted_o !== exp_halt[i] || hold_flag_o !== exp_hold[i]) begin
                errors++; $display("FAIL halt_jump[%0d] got=%0b/%0d exp=%0b/%0d",
                                   i, halted_o, hold_flag_o, exp_halt[i], exp_hold[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0100;
        tick();
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (hold_flag_o !== 3'd3 || jump_flag_o !== 1'b0) begin
            errors++; $display("FAIL mid_flush_rst got=%0d/%0b exp=3/0", hold_flag_o, jump_flag_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            rst = 1'b0;
            #2;
            checks++;
            if (hold_flag_o !== 3'd0 || halted_o !== 1'b0) begin
                errors++; $display("FAIL post_flush_rst[%0d] got=%0d/%0b exp=0/0", i, hold_flag_o, halted_o);
            end
        end
        halt_req_i = 1'b1;
        tick();
        tick();
        halt_req_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        checks++;
        if (hold_flag_o !== 3'd0 || halted_o !== 1'b0) begin
            errors++; $display("FAIL post_halt_rst got=%0d/%0b exp=0/0", hold_flag_o, halted_o);
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_stall;
        logic [31:0] exp_jump;
`ifdef PIPE_CTRL_PERF_EN
        exp_stall = 32'd10 + 32'd3 + 32'd3 * 32'(FC);
        exp_jump  = 32'd3;
`else
        exp_stall = 32'd0;
        exp_jump  = 32'd0;
`endif
        do_reset();
        for (int i = 0; i < 10; i++) begin
            hold_bus_i = 1'b1;
            tick();
        end
        hold_bus_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            jump_flag_i = 1'b1;
            jump_addr_i = 32'h1000 + 32'(j);
            tick();
            idle_inputs();
            for (int k = 0; k < FC; k++) tick();
        end
        #2;
        checks++;
        if (stall_cnt_o !== exp_stall) begin errors++; $display("FAIL perf_stall got=%0d exp=%0d", stall_cnt_o, exp_stall); end
        checks++;
        if (jump_cnt_o !== exp_jump) begin errors++; $display("FAIL perf_jump got=%0d exp=%0d", jump_cnt_o, exp_jump); end
`ifdef PIPE_CTRL_PERF_EN
        exp_stall = 32'hFFFF_FFFF;
        exp_jump  = 32'hFFFF_FFFF;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        force dut.jump_cnt_q  = 32'hFFFF_FFFF;
        hold_bus_i  = 1'b1;
        jump_flag_i = 1'b1;
        tick();
        release dut.stall_cnt_q;
        release dut.jump_cnt_q;
        tick();
        tick();
        idle_inputs();
        #2;
`endif
        checks++;
        if (stall_cnt_o !== exp_stall || jump_cnt_o !== exp_jump) begin
            errors++; $display("FAIL perf_saturate got=%h/%h exp=%h/%h", stall_cnt_o, jump_cnt_o, exp_stall, exp_jump);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_jump();
        test_restart();
        test_stall();
        test_halt();
        test_halt_jump();
        test_reset_mid_op();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of post-jump bubble cycles (legal range 0..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port jump_flag_i, input, 1, jump request from the execute stage.
REQ-005 SHALL have port jump_addr_i, input, 32, jump target address.
REQ-006 SHALL have port hold_ex_i, input, 1, execute-stage multi-cycle busy (e.g. divider).
REQ-007 SHALL have port hold_bus_i, input, 1, bus arbiter grant lost.
REQ-008 SHALL have port hold_int_i, input, 1, interrupt controller hold.
REQ-009 SHALL have port halt_req_i, input, 1, debug halt request.
REQ-010 SHALL have port hold_flag_o, output, 3, pipeline hold level consumed by the pc, if_id and id_ex registers.
REQ-011 SHALL have port jump_flag_o, output, 1, jump to the pc register.
REQ-012 SHALL have port jump_addr_o, output, 32, jump target to the pc register.
REQ-013 SHALL have port halted_o, output, 1, core is in debug halt.
REQ-014 SHALL have ports stall_cnt_o and jump_cnt_o, output, 32 each, performance counters.

Function
REQ-015 SHALL encode hold levels as follows: Hold_None=0, Hold_Pc=1, Hold_If=2, Hold_Id=3; a higher value holds more stages.
REQ-016 SHALL implement the FSM states IDLE, FLUSH and HALT.
REQ-017 SHALL drive jump_flag_o=jump_flag_i and jump_addr_o=jump_addr_i combinationally, with zero latency.
REQ-018 SHALL drive jump_addr_o=0 whenever jump_flag_i=0.
REQ-019 SHALL drive hold_flag_o combinationally as the maximum of all of the following active contributions: jump_flag_i gives Hold_Id; hold_ex_i gives Hold_Id; hold_int_i gives Hold_Id; hold_bus_i gives Hold_Pc; state FLUSH gives Hold_Id; state HALT gives Hold_Pc.
REQ-020 SHALL, with jump_flag_i=1 and FLUSH_CYCLES>0, go to FLUSH next cycle from any state and load flush_cnt=FLUSH_CYCLES.
REQ-021 SHALL decrement flush_cnt by one each cycle while in FLUSH.
REQ-022 SHALL leave FLUSH when flush_cnt reaches 1, going to HALT if halt_req_i=1 and to IDLE otherwise.
REQ-023 SHALL, with FLUSH_CYCLES=0, never enter FLUSH.
REQ-024 SHALL treat jump_flag_i=1 during FLUSH as a restart: flush_cnt reloads to FLUSH_CYCLES and the new address is passed through.
REQ-025 SHALL, in IDLE with halt_req_i=1 and jump_flag_i=0, go to HALT next cycle.
REQ-026 SHALL, in HALT, stay while halt_req_i=1 and return to IDLE the cycle after halt_req_i=0.
REQ-027 SHALL give a jump in HALT priority over the halt, so the FSM goes to FLUSH.
REQ-028 SHALL drive halted_o=1 exactly when the state is HALT (registered).
REQ-029 SHALL not let the stall inputs change FSM state; they affect hold_flag_o only.

Reset
REQ-030 SHALL, on a clk edge with rst=1, set state=IDLE, flush_cnt=0 and both counters to 0, regardless of current state or inputs.
REQ-031 SHALL force hold_flag_o=Hold_Id, jump_flag_o=0, jump_addr_o=0 and halted_o=0 while rst=1.
REQ-032 SHALL, when rst is asserted mid-FLUSH or mid-HALT, abort the operation with no residual bubbles after rst deasserts.

Configuration
REQ-033 SHALL use macro PIPE_CTRL_PERF_EN to compile the performance counters in or out.
REQ-034 SHALL, when PIPE_CTRL_PERF_EN is defined, increment stall_cnt_o each cycle hold_flag_o!=Hold_None and rst=0.
REQ-035 SHALL, when PIPE_CTRL_PERF_EN is defined, increment jump_cnt_o each cycle jump_flag_i=1 and rst=0.
REQ-036 SHALL make both counters saturate at 0xFFFFFFFF.
REQ-037 SHALL, when PIPE_CTRL_PERF_EN is undefined, keep the ports, tie both to constant 0 and instantiate no counter flops.

Verification
REQ-038 SHALL cover: FLUSH_CYCLES=2, single-cycle jump_flag_i=1 with addr 0x0000_0100 -> same cycle jump_flag_o=1, jump_addr_o=0x100 and hold=3; next 2 cycles hold=3; then hold=0.
REQ-039 SHALL cover: second jump (addr 0x200) in the 1st FLUSH cycle -> passthrough 0x200, then 2 further hold=3 cycles (3 total after the first jump cycle).
REQ-040 SHALL cover: hold_bus_i=1 and hold_ex_i=1 together in IDLE -> hold=3; drop hold_ex_i -> hold=1 the same cycle; state stays IDLE.
REQ-041 SHALL cover: halt_req_i=1 for 5 cycles -> halted_o=1 from cycle 2 to cycle 6, hold=1 while halted, IDLE one cycle after release.
REQ-042 SHALL cover: rst=1 for one cycle mid-FLUSH (flush_cnt=2) -> next cycle state IDLE and hold=0, with no remaining bubbles.
REQ-043 SHALL cover, with PIPE_CTRL_PERF_EN: 10 stall cycles plus 3 jumps -> stall_cnt_o=10+3+3*FLUSH_CYCLES and jump_cnt_o=3; with the counter preloaded to 0xFFFFFFFF it stays saturated; without the macro both read 0.
